uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default 4, giving the pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port wr_en  input  1  host write strobe; one byte per asserted cycle.
REQ-007 Port wr_data  input  8  host byte, sampled when wr_en=1.
REQ-008 Port tx_busy  input  1  busy flag from the UART transmitter.
REQ-009 Port tx_start  output  1  start request to the transmitter.
REQ-010 Port data_out  output  8  byte presented to the transmitter data_in.
REQ-011 Port full  output  1  FIFO holds DEPTH bytes.
REQ-012 Port empty  output  1  FIFO holds 0 bytes.
REQ-013 Port count  output  AW+1  bytes in the FIFO, excluding the byte in the holding register.
REQ-014 Port overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 Storage SHALL be a circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-016 A write SHALL be accepted when wr_en=1 and full=0: the byte is stored at the write pointer, and the write pointer and count are incremented on the next edge.
REQ-017 When wr_en=1 and full=1, the write SHALL be dropped, even if a pop occurs in the same cycle, and overflow SHALL be 1 in the following cycle only.
REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-019 full SHALL be (count==DEPTH), and empty SHALL be (count==0), both derived from registered count.
REQ-020 The FSM states SHALL be IDLE, LOAD, REQ and WAIT.
REQ-021 IDLE: if empty=0 and tx_busy=0, the block SHALL pop the head byte into the data_out holding register and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-022 LOAD: the FSM SHALL go to REQ on the next edge, giving one settle cycle with data_out stable.
REQ-023 REQ: tx_start SHALL be 1, and data_out SHALL be held; when tx_busy=1 is sampled, the FSM SHALL go to WAIT.
REQ-024 WAIT: tx_start SHALL be 0; when tx_busy=0 is sampled, the FSM SHALL go to IDLE.
REQ-025 tx_start SHALL be a registered output, asserted only in REQ, and held for as many cycles as needed, because the transmitter runs on a divided clock.
REQ-026 data_out SHALL change only on the pop in IDLE and SHALL otherwise hold its last value.
REQ-027 Host writes SHALL be accepted in every FSM state.
REQ-028 Minimum latency from a write into an empty, idle FIFO to tx_start=1 SHALL be 3 cycles (write, pop, load).

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL set the pointers to 0, count=0, empty=1, full=0, overflow=0, tx_start=0, data_out=8'h00 and FSM=IDLE.
REQ-030 Reset mid-transfer SHALL discard all stored bytes and the holding register, and SHALL drop tx_start on the next edge.
REQ-031 wr_en asserted in a cycle with reset=1 SHALL be ignored.
REQ-032 FIFO memory contents SHALL NOT need reset.

Verification
REQ-033 The bench SHALL apply reset for 2 cycles and then release it, and SHALL check empty=1, full=0, count=0, tx_start=0, data_out=8'h00.
REQ-034 The bench SHALL hold tx_busy=1 and write 8'hA5; it SHALL check count=1 and tx_start=0; after tx_busy=0 it SHALL check data_out=8'hA5 and tx_start=1 two cycles later.
REQ-035 The bench SHALL hold tx_busy=1 and write 17 bytes 8'h00..8'h10 with DEPTH=16; it SHALL check full=1 after 16 writes, overflow pulsing once, and byte 8'h10 lost.
REQ-036 The bench SHALL fill and drain 40 bytes with a transmitter model that raises tx_busy 5 cycles after tx_start and holds it for 20 cycles; it SHALL check all bytes are delivered in order and each tx_start is held until tx_busy=1.
REQ-037 The bench SHALL write with wr_en=1 in the same cycle as an IDLE pop at count=4, and SHALL check count remains 4.
REQ-038 The bench SHALL assert reset while in REQ with 3 bytes queued, and SHALL check tx_start=0, count=0 and empty=1 on the next edge.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-byte circular FIFO (wr_en/wr_data in; full/empty/count/overflow status) feeding a UART via data_out/tx_start with a tx_busy handshake
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    data_out,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] data_q;
  logic tx_start_q, ovf_q, wr_ok, pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign tx_start = tx_start_q;
  assign data_out = data_q;
  assign overflow = ovf_q;
  assign wr_ok = wr_en && !full;
  assign pop = state_q == IDLE && !empty && !tx_busy;
  always_comb begin
    wptr_d = wptr_q + AW'(wr_ok);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = pop ? LOAD : IDLE;
      LOAD: state_d = REQ;
      REQ:  state_d = tx_busy ? WAIT : REQ;
      WAIT: state_d = tx_busy ? WAIT : IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (wr_ok && !reset) mem[wptr_q] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      data_q <= '0;
      tx_start_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      tx_start_q <= state_d == REQ;
      ovf_q <= wr_en && full;
      if (pop) data_q <= mem[rptr_q];
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a queue-based model
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, reset = 1, wr_en = 0, tx_busy = 0;
  logic [7:0] wr_data = 0;
  logic tx_start, full, empty, overflow;
  logic [7:0] data_out;
  logic [AW:0] count;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] b[4];
  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .data_out(data_out), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int nw);
    int sent = 0, dly = 0, hold = 0, cyc = 0;
    logic ps, pb;
    tx_busy = 0;
    while ((sent < nw || q.size() > 0 || dly > 0 || hold > 0) && cyc < 20000) begin
      if (sent < nw && !full && $urandom_range(0, 3) != 0) begin
        wr_en = 1;
        wr_data = 8'($urandom);
        q.push_back(wr_data);
        sent++;
      end else wr_en = 0;
      ps = tx_start;
      pb = tx_busy;
      step();
      cyc++;
      if (ps && !pb) chk("start_held", tx_start, 1);
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_busy = 0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tx_busy = 1;
          hold = 20;
        end
      end else if (tx_start) begin
        if (q.size() == 0) chk("extra_byte", data_out, 32'hFFFF_FFFF);
        else chk("order", data_out, q.pop_front());
        dly = 5;
      end
    end
    wr_en = 0;
    chk("drain_timeout", cyc < 20000, 1);
  endtask
  initial begin
    logic acc;
    reset = 1;
    wr_en = 1;
    wr_data = 8'h33;
    step();
    step();
    reset = 0;
    wr_en = 0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", data_out, 8'h00);
    tx_busy = 1;
    wr_en = 1;
    wr_data = 8'hA5;
    step();
    wr_en = 0;
    chk("a5_count", count, 1);
    chk("a5_nostart", tx_start, 0);
    tx_busy = 0;
    step();
    step();
    chk("a5_data", data_out, 8'hA5);
    chk("a5_start", tx_start, 1);
    chk("a5_count0", count, 0);
    tx_busy = 1;
    step();
    chk("wait_nostart", tx_start, 0);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1;
      wr_data = 8'(i);
      acc = q.size() < DEPTH;
      if (acc) q.push_back(wr_data);
      step();
      chk("fill_ovf", overflow, !acc);
      chk("fill_count", count, q.size());
      if (i == 15) chk("fill_full", full, 1);
    end
    wr_en = 0;
    step();
    chk("ovf_once", overflow, 0);
    run(0);
    step();
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    run(40);
    step();
    chk("rand_empty", empty, 1);
    chk("rand_count", count, 0);
    tx_busy = 1;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      wr_en = 1;
      wr_data = b[i];
      step();
    end
    wr_en = 0;
    chk("pre_pop_count", count, 4);
    tx_busy = 0;
    wr_en = 1;
    wr_data = 8'h5A;
    step();
    wr_en = 0;
    chk("wrpop_count", count, 4);
    chk("wrpop_data", data_out, b[0]);
    reset = 1;
    step();
    reset = 0;
    chk("rst2_count", count, 0);
    tx_busy = 1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1;
      wr_data = 8'(8'h40 + i);
      step();
    end
    wr_en = 0;
    tx_busy = 0;
    step();
    step();
    chk("req_start", tx_start, 1);
    chk("req_count", count, 3);
    chk("req_data", data_out, 8'h40);
    reset = 1;
    step();
    reset = 0;
    chk("midrst_start", tx_start, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_data", data_out, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
